// File: rtl/simeck_decryption32.sv
// Iterative Simeck-style 32-bit block decryption core with a 16-bit key.
// One inverse Feistel round per clock, rounds 31 down to 0, start/done handshake.
module simeck_decryption32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] inp,
    input  logic [15:0] key,
    output logic [31:0] out,
    output logic        busy,
    output logic        done
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  round_q;
    logic [15:0] left_q, right_q, key_q;
    logic [15:0] round_left, round_right;
    logic        load, last;

    function automatic logic [15:0] rotl(input logic [15:0] x, input int unsigned n);
        rotl = (x << n) | (x >> (16 - n));
    endfunction

    function automatic logic [15:0] round_f(input logic [15:0] x);
        round_f = (x & rotl(x, 5)) ^ rotl(x, 1);
    endfunction

    // Inverse round: (L, R) -> (R, L ^ f(R) ^ k_i) with k_i = K ^ i.
    always_comb begin
        round_left  = right_q;
        round_right = left_q ^ round_f(right_q) ^ (key_q ^ {11'b0, round_q});
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (round_q == 5'd0) begin
                    state_d = IDLE;
                    last    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            round_q <= 5'd0;
            out     <= 32'd0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= last;
            if (load) begin
                round_q <= 5'd31;
            end else if (state_q == RUN && !last) begin
                round_q <= round_q - 5'd1;
            end
            if (last) begin
                out <= {round_left, round_right};
            end
        end
    end

    // NOTE: working datapath registers are left unreset; they are always loaded before being used.
    always_ff @(posedge clk) begin
        if (load) begin
            left_q  <= inp[31:16];
            right_q <= inp[15:0];
            key_q   <= key;
        end else if (state_q == RUN) begin
            left_q  <= round_left;
            right_q <= round_right;
        end
    end

    assign busy = (state_q == RUN);

endmodule

// File: tb/tb_simeck_decryption32.sv
// Self-checking bench for simeck_decryption32: randomized and directed
// stimulus, scoreboard queue, negedge monitor against a loop-based cipher model.
module tb_simeck_decryption32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b1;
    logic [31:0] inp = 32'd0;
    logic [15:0] key = 16'd0;
    logic [31:0] out;
    logic        busy;
    logic        done;

    simeck_decryption32 dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .inp  (inp),
        .key  (key),
        .out  (out),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] pt;
        int          start_cyc;
    } exp_t;
    exp_t sb[$];

    int          done_cnt = 0;
    logic [31:0] last_out = 32'd0;
    bit          sweep_mode = 1'b0;
    int          sweep_prev = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Reference model: straight from the round rules, plain loops.
    function automatic logic [15:0] m_rotl(input logic [15:0] x, input int n);
        return (x << n) | (x >> (16 - n));
    endfunction

    function automatic logic [15:0] m_f(input logic [15:0] x);
        return (x & m_rotl(x, 5)) ^ m_rotl(x, 1);
    endfunction

    function automatic logic [31:0] m_encrypt(input logic [31:0] pt, input logic [15:0] k);
        logic [15:0] l, r, t;
        l = pt[31:16];
        r = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            t = r ^ m_f(l) ^ (k ^ 16'(i));
            r = l;
            l = t;
        end
        return {l, r};
    endfunction

    function automatic logic [31:0] m_decrypt(input logic [31:0] ct, input logic [15:0] k);
        logic [15:0] l, r, t;
        l = ct[31:16];
        r = ct[15:0];
        for (int i = 31; i >= 0; i--) begin
            t = l ^ m_f(r) ^ (k ^ 16'(i));
            l = r;
            r = t;
        end
        return {l, r};
    endfunction

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            last_out = out;
            check("sb_nonempty_on_done", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("plaintext", out, e.pt);
                check("latency", 32'(cyc - e.start_cyc), 32'd32);
                check("busy_low_on_done", 32'(busy), 32'd0);
            end
            if (sweep_mode) begin
                if (sweep_prev >= 0) check("done_spacing", 32'(cyc - sweep_prev), 32'd33);
                sweep_prev = cyc;
            end
        end
    end

    task automatic wait_idle();
        int budget = 0;
        @(negedge clk);
        while (busy && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (busy) check("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    // Starts one operation once idle; leaves the bench at the negedge after E0.
    task automatic issue(input logic [31:0] ct, input logic [15:0] k,
                         input bit push, input logic [31:0] pt);
        exp_t e;
        wait_idle();
        start = 1'b1;
        inp   = ct;
        key   = k;
        if (push) begin
            e.pt        = pt;
            e.start_cyc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        inp   = $urandom;
        key   = 16'($urandom);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got 0 expected 1");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ct, out_k0, out_k1;
        int          base_cnt;

        // Reset held with start high: nothing may begin.
        repeat (2) begin
            @(negedge clk);
            check("reset_out", out, 32'd0);
            check("reset_busy", 32'(busy), 32'd0);
            check("reset_done", 32'(done), 32'd0);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("no_start_after_reset", 32'(busy), 32'd0);

        // Round trip with the reference encryptor.
        ct = m_encrypt(32'h6565_6877, 16'hB5E5);
        issue(ct, 16'hB5E5, 1'b1, 32'h6565_6877);
        check("busy_after_start", 32'(busy), 32'd1);

        // Counter sweep, back to back; done spacing checked by the monitor.
        wait_idle();
        @(negedge clk);
        sweep_mode = 1'b1;
        sweep_prev = -1;
        for (int i = 0; i <= 50; i++)
            issue(32'(i), 16'hB5E5, 1'b1, m_decrypt(32'(i), 16'hB5E5));
        wait_idle();
        @(negedge clk);
        sweep_mode = 1'b0;

        // Start pulses while busy must be ignored.
        ct = $urandom;
        base_cnt = done_cnt;
        issue(ct, 16'h1234, 1'b1, m_decrypt(ct, 16'h1234));
        repeat (4) @(negedge clk);
        start = 1'b1; inp = ~ct; key = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        check("busy_held_c5", 32'(busy), 32'd1);
        repeat (14) @(negedge clk);
        start = 1'b1; inp = 32'hDEAD_BEEF; key = 16'h0F0F;
        @(negedge clk);
        start = 1'b0;
        check("busy_held_c20", 32'(busy), 32'd1);
        wait_idle();
        @(negedge clk);
        check("single_done", 32'(done_cnt - base_cnt), 32'd1);
        check("idle_after_done", 32'(busy), 32'd0);

        // Reset at round 10 (edge E22) aborts with no done pulse.
        base_cnt = done_cnt;
        issue($urandom, 16'($urandom), 1'b0, 32'd0);
        repeat (21) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out", out, 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (40) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - base_cnt), 32'd0);
        ct = $urandom;
        issue(ct, 16'hA5A5, 1'b1, m_decrypt(ct, 16'hA5A5));
        wait_idle();

        // Key sensitivity.
        ct = $urandom;
        issue(ct, 16'h0000, 1'b1, m_decrypt(ct, 16'h0000));
        wait_idle();
        @(negedge clk);
        out_k0 = last_out;
        issue(ct, 16'hFFFF, 1'b1, m_decrypt(ct, 16'hFFFF));
        wait_idle();
        @(negedge clk);
        out_k1 = last_out;
        check("key_outputs_differ", 32'(out_k0 != out_k1), 32'd1);

        // A few random blocks with random keys.
        for (int i = 0; i < 8; i++) begin
            logic [15:0] k;
            ct = $urandom;
            k  = 16'($urandom);
            issue(ct, k, 1'b1, m_decrypt(ct, k));
        end
        wait_idle();
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
